// File: rtl/ring_logger.sv
// ring_logger: buffers 2-word samples in a circular region of an external
// two-word memory controller; FIFO pop interface with nack on empty and a
// sticky overflow flag for samples dropped while the ring is full.
module ring_logger #(
  parameter int M_WIDTH = 8,
  parameter int M_DEPTH = 8192,
  parameter int BASE    = 0,
  parameter int SLOTS   = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [2*M_WIDTH-1:0]         wr_data,
  input  logic                         rd_req,
  output logic                         rd_valid,
  output logic                         rd_nack,
  output logic [2*M_WIDTH-1:0]         rd_data,
  output logic [$clog2(SLOTS+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic [2:0]                   mem_cmd,
  output logic [$clog2(M_DEPTH)-1:0]   mem_addr,
  output logic [M_WIDTH-1:0]           mem_din1,
  output logic [M_WIDTH-1:0]           mem_din2,
  input  logic [M_WIDTH-1:0]           mem_dout1,
  input  logic [M_WIDTH-1:0]           mem_dout2,
  input  logic                         mem_done
);

  localparam int AW = $clog2(M_DEPTH);
  localparam int CW = $clog2(SLOTS + 1);
  localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [AW-1:0] BASE_A = AW'(BASE);
  localparam logic [2:0] CMD_WR   = 3'b111;
  localparam logic [2:0] CMD_RD   = 3'b101;
  localparam logic [2:0] CMD_NONE = 3'b000;

  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_REL, RD_ISSUE, RD_REL} state_t;

  state_t              state, state_n;
  logic [PW-1:0]       wptr, rptr;
  logic                hold_valid;
  logic [2*M_WIDTH-1:0] hold_data;
  logic                rd_pend;
  logic                clr_pend;
  logic                last_wr;

  logic do_clr, do_drop, do_wr_issue, do_wr_done;
  logic do_nack, do_rd_issue, do_rd_done;

  assign wr_ready = ~hold_valid;
  assign full     = (count == CW'(SLOTS));
  assign empty    = (count == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and one dispatch action per IDLE cycle
  always_comb begin
    state_n     = state;
    do_clr      = 1'b0;
    do_drop     = 1'b0;
    do_wr_issue = 1'b0;
    do_wr_done  = 1'b0;
    do_nack     = 1'b0;
    do_rd_issue = 1'b0;
    do_rd_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr || clr_pend) begin
          do_clr = 1'b1;
        end else if (hold_valid && (!rd_pend || !last_wr)) begin
          if (full) do_drop = 1'b1;
          else begin
            do_wr_issue = 1'b1;
            state_n     = WR_ISSUE;
          end
        end else if (rd_pend) begin
          if (empty) do_nack = 1'b1;
          else begin
            do_rd_issue = 1'b1;
            state_n     = RD_ISSUE;
          end
        end
      end
      WR_ISSUE: if (mem_done) begin
        do_wr_done = 1'b1;
        state_n    = WR_REL;
      end
      WR_REL:   if (!mem_done) state_n = IDLE;
      RD_ISSUE: if (mem_done) begin
        do_rd_done = 1'b1;
        state_n    = RD_REL;
      end
      RD_REL:   if (!mem_done) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Datapath: pointers, count, flags, holding register and memory request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      rd_pend    <= 1'b0;
      clr_pend   <= 1'b0;
      last_wr    <= 1'b0;
      mem_cmd    <= CMD_NONE;
      mem_addr   <= '0;
      mem_din1   <= '0;
      mem_din2   <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_nack    <= 1'b0;
    end else begin
      rd_valid <= do_rd_done;
      rd_nack  <= do_nack;

      if (do_drop || do_wr_done) hold_valid <= 1'b0;
      else if (wr_valid && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_data  <= wr_data;
      end

      if (do_nack || do_rd_done) rd_pend <= 1'b0;
      else if (rd_req)           rd_pend <= 1'b1;

      if (state != IDLE && clr) clr_pend <= 1'b1;
      else if (do_clr)          clr_pend <= 1'b0;

      if (do_drop || do_wr_issue)      last_wr <= 1'b1;
      else if (do_nack || do_rd_issue) last_wr <= 1'b0;

      if (do_clr) begin
        wptr     <= '0;
        rptr     <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end
      if (do_drop) overflow <= 1'b1;

      if (do_wr_issue) begin
        mem_cmd  <= CMD_WR;
        mem_addr <= BASE_A + AW'({wptr, 1'b0});
        mem_din1 <= hold_data[M_WIDTH-1:0];
        mem_din2 <= hold_data[2*M_WIDTH-1:M_WIDTH];
      end
      if (do_rd_issue) begin
        mem_cmd  <= CMD_RD;
        mem_addr <= BASE_A + AW'({rptr, 1'b0});
      end

      if (do_wr_done) begin
        mem_cmd <= CMD_NONE;
        wptr    <= (wptr == PW'(SLOTS - 1)) ? '0 : wptr + 1'b1;
        count   <= count + 1'b1;
      end
      if (do_rd_done) begin
        mem_cmd <= CMD_NONE;
        rd_data <= {mem_dout2, mem_dout1};
        rptr    <= (rptr == PW'(SLOTS - 1)) ? '0 : rptr + 1'b1;
        count   <= count - 1'b1;
      end
    end
  end

endmodule
